// File: rtl/bp_be_issue_scoreboard.sv
// Issue-side RAW/WAW hazard scoreboard: per-register latency countdowns plus sticky long-op busy bits.
// Optional stall-cycle counter on stall_cnt_o when BP_BE_SCOREBOARD_PERF_EN is defined.
module bp_be_issue_scoreboard #(
  parameter int unsigned mem_latency_p    = 3,
  parameter int unsigned mul_latency_p    = 4,
  parameter int unsigned reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        issue_v_i,
  output logic                        issue_ready_o,
  input  logic                        rs1_v_i,
  input  logic                        rs2_v_i,
  input  logic [reg_addr_width_p-1:0] rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] rs2_addr_i,
  input  logic                        rd_v_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,
  input  logic [1:0]                  lat_class_i,
  output logic                        issue_v_o,
  input  logic                        issue_ready_i,
  input  logic                        long_wb_v_i,
  input  logic [reg_addr_width_p-1:0] long_wb_addr_i,
  input  logic                        flush_i,
`ifdef BP_BE_SCOREBOARD_PERF_EN
  output logic [31:0]                 stall_cnt_o,
`endif
  output logic                        busy_o
);

  localparam int unsigned max_lat_lp   = (mem_latency_p > mul_latency_p) ? mem_latency_p : mul_latency_p;
  localparam int unsigned cnt_width_lp = $clog2(max_lat_lp + 1);
  localparam int unsigned num_regs_lp  = 1 << reg_addr_width_p;

  localparam logic [1:0] class_int_lp  = 2'd0;
  localparam logic [1:0] class_mem_lp  = 2'd1;
  localparam logic [1:0] class_mul_lp  = 2'd2;
  localparam logic [1:0] class_long_lp = 2'd3;

  logic [num_regs_lp-1:0][cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [num_regs_lp-1:0]                   lbusy_q, lbusy_d;
  logic [num_regs_lp-1:0]                   pend_c;
  logic                                     busy_q, busy_d;
  logic                                     raw_c, waw_c, hazard_c, fire_c;

  // Current pending view; entry 0 is held at zero so x0 never hazards.
  always_comb begin
    pend_c = '0;
    for (int unsigned r = 1; r < num_regs_lp; r++) begin
      pend_c[reg_addr_width_p'(r)] = (cnt_q[reg_addr_width_p'(r)] != '0) | lbusy_q[reg_addr_width_p'(r)];
    end
  end

  always_comb begin
    raw_c         = (rs1_v_i & pend_c[rs1_addr_i]) | (rs2_v_i & pend_c[rs2_addr_i]);
    waw_c         = rd_v_i & lbusy_q[rd_addr_i];
    hazard_c      = raw_c | waw_c;
    issue_v_o     = reset_n_i & issue_v_i & ~hazard_c & ~flush_i;
    issue_ready_o = reset_n_i & issue_ready_i & ~hazard_c & ~flush_i;
    fire_c        = issue_v_o & issue_ready_i;
  end

  // Next-state: flush > issue set > countdown; writeback clear loses to a same-cycle long set.
  always_comb begin
    cnt_d   = cnt_q;
    lbusy_d = lbusy_q;
    busy_d  = 1'b0;
    if (flush_i) begin
      cnt_d   = '0;
      lbusy_d = '0;
    end else begin
      for (int unsigned r = 0; r < num_regs_lp; r++) begin
        if (cnt_q[reg_addr_width_p'(r)] != '0) begin
          cnt_d[reg_addr_width_p'(r)] = cnt_q[reg_addr_width_p'(r)] - cnt_width_lp'(1);
        end
      end
      if (long_wb_v_i) begin
        lbusy_d[long_wb_addr_i] = 1'b0;
      end
      if (fire_c && rd_v_i && (rd_addr_i != '0)) begin
        case (lat_class_i)
          class_mem_lp:  cnt_d[rd_addr_i]   = cnt_width_lp'(mem_latency_p);
          class_mul_lp:  cnt_d[rd_addr_i]   = cnt_width_lp'(mul_latency_p);
          class_long_lp: lbusy_d[rd_addr_i] = 1'b1;
          class_int_lp:  ;
          default:       ;
        endcase
      end
    end
    cnt_d[0]   = '0;
    lbusy_d[0] = 1'b0;
    for (int unsigned r = 0; r < num_regs_lp; r++) begin
      busy_d = busy_d | (cnt_d[reg_addr_width_p'(r)] != '0) | lbusy_d[reg_addr_width_p'(r)];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      lbusy_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lbusy_q <= lbusy_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;

`ifdef BP_BE_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where both sides are ready but a hazard holds the packet.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_v_i && issue_ready_i && hazard_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/bp_be_issue_scoreboard.md
Name: bp_be_issue_scoreboard

Overview:
- Issue-side hazard controller between the BE scheduler's issue packet and the calculator.
- Tracks in-flight destination registers with per-register countdown timers plus a sticky busy bit for long-latency ops (div/sqrt).
- Withholds the issue handshake while a RAW or WAW hazard exists.
- Flushes all tracking state on pipeline redirect.

Parameters:
- mem_latency_p, 3, cycles from issue until a load result is bypassable.
- mul_latency_p, 4, cycles from issue until a multiply result is bypassable.
- reg_addr_width_p, 5, architectural register address width (32 regs).
- Derived: cnt_width_lp = clog2(max(mem_latency_p, mul_latency_p)+1).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- issue_v_i  in  1  upstream issue packet valid
- issue_ready_o  out  1  upstream may hand over packet
- rs1_v_i  in  1  packet reads rs1
- rs2_v_i  in  1  packet reads rs2
- rs1_addr_i  in  reg_addr_width_p  rs1 address
- rs2_addr_i  in  reg_addr_width_p  rs2 address
- rd_v_i  in  1  packet writes rd
- rd_addr_i  in  reg_addr_width_p  destination address
- lat_class_i  in  2  0=int, 1=mem, 2=mul, 3=long
- issue_v_o  out  1  packet forwarded to calculator
- issue_ready_i  in  1  calculator accepts
- long_wb_v_i  in  1  long-latency writeback valid
- long_wb_addr_i  in  reg_addr_width_p  long writeback rd
- flush_i  in  1  redirect; clear all tracking
- busy_o  out  1  any register pending

Behaviour:
- Reset: async on reset_n_i low. All counters=0, all long-busy bits=0; issue_ready_o=0, issue_v_o=0, busy_o=0 while asserted.
- Per-register state, regs 1..31 only: cnt[r] (cnt_width_lp) and lbusy[r] (1 bit). Reg 0 is never tracked and never hazards.
- pending(r) = (cnt[r]!=0) | lbusy[r].
- raw = (rs1_v_i & pending(rs1_addr_i)) | (rs2_v_i & pending(rs2_addr_i)).
- waw = rd_v_i & lbusy[rd_addr_i] (in-order writeback protection for long ops only).
- hazard = raw | waw.
- Handshake, combinational, 0-cycle latency:
  - issue_v_o = issue_v_i & ~hazard & ~flush_i.
  - issue_ready_o = issue_ready_i & ~hazard & ~flush_i.
  - Fire = issue_v_o & issue_ready_i.
- Counter update each cycle, priority high to low:
  1. flush_i: all cnt=0 and all lbusy=0 next cycle. Fire is blocked, so nothing is set.
  2. Fire with rd_v_i and rd_addr_i!=0:
     - class 0: nothing set (fully bypassed).
     - class 1: cnt[rd] <= mem_latency_p.
     - class 2: cnt[rd] <= mul_latency_p.
     - class 3: lbusy[rd] <= 1.
     - The set takes priority over same-cycle decrement of that entry.
  3. Every other nonzero cnt decrements by 1, saturating at 0.
  4. long_wb_v_i clears lbusy[long_wb_addr_i]. If the same cycle also fires class 3 to the same rd, the set wins. A waw stall normally prevents this case.
- Same-cycle writeback and read:
  - long_wb_v_i for r in cycle t does not clear a hazard on r in cycle t; the hazard drops in cycle t+1.
  - cnt reaching 0 at the edge releases the hazard the next cycle.
- A class 1/2 issue to rd with cnt[rd]!=0 is legal: cnt is overwritten with the new latency.
- busy_o = OR of pending(r), registered view of current state.
- Reset asserted mid-operation discards all state immediately. No issue until reset_n_i returns high.

Optional Feature:
- Macro BP_BE_SCOREBOARD_PERF_EN.
- Defined:
  - Adds output stall_cnt_o [31:0], counting cycles with issue_v_i & issue_ready_i & hazard.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by reset_n_i. Not cleared by flush_i.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Mem RAW: issue class 1 rd=5 at t0; at t1 present rs1=5 with ready_i=1 -> issue_v_o=0 for t1..t3, =1 at t4 (mem_latency_p=3).
- Long op: issue class 3 rd=7; dependent rs2=7 stalls indefinitely; long_wb_v_i rd=7 at t10 -> issue_v_o=1 at t11.
- WAW: lbusy[9]=1, packet rd_v=1 rd=9 no sources -> stalled until long writeback to 9. A class 2 rd=9 pending with cnt=2 does not stall.
- x0: class 2 issue rd=0, next packet rs1=0 -> no stall, busy_o stays 0.
- Flush: cnt[3]=4, lbusy[4]=1, flush_i pulse -> issue_ready_o=0 that cycle; next cycle busy_o=0 and rs1=3/rs2=4 issue immediately.
- Async reset: assert reset_n_i low mid-stall without a clock edge -> issue_ready_o/issue_v_o/busy_o drop to 0 at once; after release all registers read as free.
